iob_cache_be_arbiter: RTL and testbench

- Shares the single native back-end memory port between two cache requesters.
  - The line-refill read channel issues bursts of 2^LINE2BE_W words.
  - The write-through write channel issues single-word writes.
- Sits between those two channels and the cache's back-end interface.
- Holds the grant for a whole refill burst, so refill words are never interleaved with writes.

---
 rtl/iob_cache_be_arbiter_if.sv | 40 ++++
 rtl/iob_cache_be_arbiter.sv | 115 +++++++++++
 tb/tb_iob_cache_be_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_be_arbiter_if.sv
// Back-end arbiter bus: refill read channel, write-through channel
// and the shared native memory port, bundled for the arbiter.
interface iob_cache_be_arbiter_if #(
    parameter int BE_ADDR_W = 32,
    parameter int BE_DATA_W = 32
);
    logic                   rd_valid_i;
    logic [BE_ADDR_W-1:0]   rd_addr_i;
    logic [BE_DATA_W-1:0]   rd_rdata_o;
    logic                   rd_ready_o;
    logic                   wr_valid_i;
    logic [BE_ADDR_W-1:0]   wr_addr_i;
    logic [BE_DATA_W-1:0]   wr_wdata_i;
    logic [BE_DATA_W/8-1:0] wr_wstrb_i;
    logic                   wr_ready_o;
    logic                   be_valid_o;
    logic [BE_ADDR_W-1:0]   be_addr_o;
    logic [BE_DATA_W-1:0]   be_wdata_o;
    logic [BE_DATA_W/8-1:0] be_wstrb_o;
    logic [BE_DATA_W-1:0]   be_rdata_i;
    logic                   be_ready_i;

    // Arbiter side
    modport slave (
        input  rd_valid_i, rd_addr_i,
        input  wr_valid_i, wr_addr_i, wr_wdata_i, wr_wstrb_i,
        input  be_rdata_i, be_ready_i,
        output rd_rdata_o, rd_ready_o, wr_ready_o,
        output be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o
    );

    // Requesters plus memory side
    modport master (
        output rd_valid_i, rd_addr_i,
        output wr_valid_i, wr_addr_i, wr_wdata_i, wr_wstrb_i,
        output be_rdata_i, be_ready_i,
        input  rd_rdata_o, rd_ready_o, wr_ready_o,
        input  be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o
    );
endinterface

// File: rtl/iob_cache_be_arbiter.sv
// Back-end port arbiter: refill bursts vs write-through writes.
// Define IOB_CACHE_BE_ARB_RR_EN for alternating priority on ties.
module iob_cache_be_arbiter #(
    parameter int BE_ADDR_W = 32,
    parameter int BE_DATA_W = 32,
    parameter int LINE2BE_W = 2
) (
    input  logic clk_i,
    input  logic reset,
    iob_cache_be_arbiter_if.slave bus,
    output logic busy_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_RD = 2'd1,
        GNT_WR = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rd_ready;
    logic   wr_ready;
    logic   last_beat;
    logic   pick_wr;

    generate
        if (LINE2BE_W > 0) begin : g_cnt
            localparam logic [LINE2BE_W-1:0] CNT_ONE = LINE2BE_W'(1);
            logic [LINE2BE_W-1:0] cnt_q, cnt_d;

            // Beat counter advances per accepted refill beat, wraps at line end
            always_comb begin
                cnt_d = cnt_q;
                if (rd_ready) cnt_d = cnt_q + CNT_ONE;
            end

            // Beat counter register
            always_ff @(posedge clk_i or posedge reset) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign last_beat = (cnt_q == {LINE2BE_W{1'b1}});
        end else begin : g_nocnt
            assign last_beat = 1'b1;
        end
    endgenerate

`ifdef IOB_CACHE_BE_ARB_RR_EN
    logic prio_wr_q, prio_wr_d;

    // Tie winner flips to whoever was not granted last
    always_comb begin
        prio_wr_d = prio_wr_q;
        if (state_q == IDLE && state_d != IDLE)
            prio_wr_d = (state_d == GNT_RD);
    end

    // Tie priority register; write wins the first tie
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) prio_wr_q <= 1'b1;
        else       prio_wr_q <= prio_wr_d;
    end

    assign pick_wr = prio_wr_q;
`else
    assign pick_wr = 1'b1;
`endif

    // Grant register
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next grant and port muxing; IDLE drives nothing
    always_comb begin
        state_d        = state_q;
        rd_ready       = 1'b0;
        wr_ready       = 1'b0;
        bus.be_valid_o = 1'b0;
        bus.be_addr_o  = '0;
        bus.be_wdata_o = '0;
        bus.be_wstrb_o = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_valid_i && bus.rd_valid_i)
                    state_d = pick_wr ? GNT_WR : GNT_RD;
                else if (bus.wr_valid_i)
                    state_d = GNT_WR;
                else if (bus.rd_valid_i)
                    state_d = GNT_RD;
            end
            GNT_RD: begin
                bus.be_valid_o = bus.rd_valid_i;
                bus.be_addr_o  = bus.rd_addr_i;
                rd_ready       = bus.be_ready_i & bus.rd_valid_i;
                if (rd_ready && last_beat) state_d = IDLE;
            end
            GNT_WR: begin
                bus.be_valid_o = bus.wr_valid_i;
                bus.be_addr_o  = bus.wr_addr_i;
                bus.be_wdata_o = bus.wr_wdata_i;
                bus.be_wstrb_o = bus.wr_wstrb_i;
                wr_ready       = bus.be_ready_i & bus.wr_valid_i;
                if (wr_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rd_ready_o = rd_ready;
    assign bus.wr_ready_o = wr_ready;
    assign bus.rd_rdata_o = bus.be_rdata_i;
    assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Directed bench for iob_cache_be_arbiter (LINE2BE_W=2).
// Per-cycle vector table plus reset-abort and tie-alternation sequences.
module tb_iob_cache_be_arbiter;
    logic clk_i = 1'b0;
    logic reset = 1'b1;
    logic busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    iob_cache_be_arbiter_if #(.BE_ADDR_W(32), .BE_DATA_W(32)) bus ();

    iob_cache_be_arbiter #(
        .BE_ADDR_W(32),
        .BE_DATA_W(32),
        .LINE2BE_W(2)
    ) dut (
        .clk_i (clk_i),
        .reset (reset),
        .bus   (bus),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        wv;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        brdy;
        logic        bv;
        logic [31:0] ba;
        logic [31:0] bwd;
        logic [3:0]  bws;
        logic        rr;
        logic        wr;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    localparam logic [31:0] WDA = 32'hDEADBEEF;
    localparam logic [31:0] WDB = 32'h11223344;
    localparam logic [31:0] WDC = 32'hCAFEF00D;

    function automatic vec_t v(
        input logic rv, input logic [31:0] ra,
        input logic wv, input logic [31:0] wa,
        input logic [31:0] wd, input logic [3:0] ws,
        input logic brdy,
        input logic bv, input logic [31:0] ba,
        input logic [31:0] bwd, input logic [3:0] bws,
        input logic rr, input logic wr, input logic busy);
        vec_t x;
        x.rv = rv; x.ra = ra; x.wv = wv; x.wa = wa;
        x.wd = wd; x.ws = ws; x.brdy = brdy;
        x.bv = bv; x.ba = ba; x.bwd = bwd; x.bws = bws;
        x.rr = rr; x.wr = wr; x.busy = busy;
        return x;
    endfunction

    function automatic logic [71:0] outs();
        return {bus.be_valid_o, bus.be_addr_o, bus.be_wdata_o,
                bus.be_wstrb_o, bus.rd_ready_o, bus.wr_ready_o, busy_o};
    endfunction

    task automatic chk(input string name,
                       input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x, input logic [31:0] brd);
        bus.rd_valid_i = x.rv;
        bus.rd_addr_i  = x.ra;
        bus.wr_valid_i = x.wv;
        bus.wr_addr_i  = x.wa;
        bus.wr_wdata_i = x.wd;
        bus.wr_wstrb_i = x.ws;
        bus.be_ready_i = x.brdy;
        bus.be_rdata_i = brd;
    endtask

    initial begin
        vec_t z;
        int   nb;
        int   first_c;
        int   last_c;
        z = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Refill alone
        vq.push_back(v(1, 'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(1, 'h100, 0, 0, 0, 0, 1, 1, 'h100, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h104, 0, 0, 0, 0, 1, 1, 'h104, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h108, 0, 0, 0, 0, 1, 1, 'h108, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h10C, 0, 0, 0, 0, 1, 1, 'h10C, 0, 0, 1, 0, 1));
        vq.push_back(z);
        // Write alone, three wait cycles
        vq.push_back(v(0, 0, 1, 'h200, WDA, 'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 1, 'h200, WDA, 'hF, 0, 1, 'h200, WDA, 'hF, 0, 0, 1));
        vq.push_back(v(0, 0, 1, 'h200, WDA, 'hF, 0, 1, 'h200, WDA, 'hF, 0, 0, 1));
        vq.push_back(v(0, 0, 1, 'h200, WDA, 'hF, 0, 1, 'h200, WDA, 'hF, 0, 0, 1));
        vq.push_back(v(0, 0, 1, 'h200, WDA, 'hF, 1, 1, 'h200, WDA, 'hF, 0, 1, 1));
        vq.push_back(z);
        // Simultaneous: write first, IDLE gap, then full refill
        vq.push_back(v(1, 'h300, 1, 'h400, WDB, 'h3, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(1, 'h300, 1, 'h400, WDB, 'h3, 1, 1, 'h400, WDB, 'h3, 0, 1, 1));
        vq.push_back(v(1, 'h300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(1, 'h300, 0, 0, 0, 0, 1, 1, 'h300, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h304, 0, 0, 0, 0, 1, 1, 'h304, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h308, 0, 0, 0, 0, 1, 1, 'h308, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h30C, 0, 0, 0, 0, 1, 1, 'h30C, 0, 0, 1, 0, 1));
        vq.push_back(z);
        // Write raised during refill beat 2
        vq.push_back(v(1, 'h500, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(1, 'h500, 0, 0, 0, 0, 1, 1, 'h500, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h504, 1, 'h600, WDC, 'hC, 1, 1, 'h504, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h508, 1, 'h600, WDC, 'hC, 1, 1, 'h508, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h50C, 1, 'h600, WDC, 'hC, 1, 1, 'h50C, 0, 0, 1, 0, 1));
        vq.push_back(v(0, 0, 1, 'h600, WDC, 'hC, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 1, 'h600, WDC, 'hC, 1, 1, 'h600, WDC, 'hC, 0, 1, 1));
        vq.push_back(z);
        // Valid dropped mid-burst: grant and beat count held
        vq.push_back(v(1, 'h700, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(1, 'h700, 0, 0, 0, 0, 1, 1, 'h700, 0, 0, 1, 0, 1));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(v(1, 'h704, 0, 0, 0, 0, 0, 1, 'h704, 0, 0, 0, 0, 1));
        vq.push_back(v(1, 'h704, 0, 0, 0, 0, 1, 1, 'h704, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h708, 0, 0, 0, 0, 1, 1, 'h708, 0, 0, 1, 0, 1));
        vq.push_back(v(1, 'h70C, 0, 0, 0, 0, 1, 1, 'h70C, 0, 0, 1, 0, 1));
        vq.push_back(z);

        // Reset with both requests asserted: everything quiet
        drive(v(1, 'h900, 1, 'h904, WDA, 'hF, 1, 0, 0, 0, 0, 0, 0, 0), 32'h5);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_state", outs(), 72'h0);
        drive(z, 0);
        reset = 1'b0;

        foreach (vq[i]) begin
            logic [31:0] brd;
            brd = 32'hA5000000 | 32'(i);
            @(posedge clk_i);
            #1;
            drive(vq[i], brd);
            @(negedge clk_i);
            chk($sformatf("vec%0d", i), outs(),
                {vq[i].bv, vq[i].ba, vq[i].bwd, vq[i].bws,
                 vq[i].rr, vq[i].wr, vq[i].busy});
            if (vq[i].rr)
                chk($sformatf("vec%0d_rdata", i),
                    {40'h0, bus.rd_rdata_o}, {40'h0, brd});
        end

        // Reset after two refill beats aborts at once
        @(posedge clk_i);
        #1;
        drive(v(1, 'h800, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 32'h77);
        repeat (3) @(posedge clk_i);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_abort", outs(), 72'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset = 1'b0;
        nb = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 1; c <= 20 && nb < 4; c++) begin
            @(negedge clk_i);
            if (bus.be_valid_o && first_c < 0) first_c = c;
            if (bus.rd_ready_o) begin
                nb++;
                last_c = c;
            end
        end
        chk("reissue_beats", 72'(nb), 72'd4);
        chk("reissue_first", 72'(first_c), 72'd1);
        chk("reissue_last", 72'(last_c), 72'd4);
        @(posedge clk_i);
        #1;
        drive(z, 0);
        @(negedge clk_i);
        chk("reissue_idle", outs(), 72'h0);

`ifdef IOB_CACHE_BE_ARB_RR_EN
        begin
            logic [3:0] order;
            int         ng;
            logic       prev_busy;
            reset = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            reset = 1'b0;
            drive(v(1, 'hA00, 1, 'hB00, WDA, 'hF, 1, 0, 0, 0, 0, 0, 0, 0), 0);
            order = '0;
            ng = 0;
            prev_busy = 1'b0;
            for (int c = 0; c < 60 && ng < 4; c++) begin
                @(negedge clk_i);
                if (busy_o && !prev_busy) begin
                    order[3-ng] = bus.wr_ready_o;
                    ng++;
                end
                prev_busy = busy_o;
            end
            chk("rr_grants", 72'(ng), 72'd4);
            chk("rr_order", 72'(order), 72'b1010);
            drive(z, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
